gemm_stream_core: RTL and testbench

//  Parametrised streaming GEMM engine: R = alpha*(A*B) + beta*C on an M x N tile, with A*B built from K outer-product beats.

---
 rtl/gemm_stream_core.sv | 213 +++++++++++++++++++++
 tb/tb_gemm_stream_core.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_stream_core.sv
`default_nettype none
// ============================================================================
// Module   : gemm_stream_core
// Purpose  : Streaming GEMM engine computing R = alpha*(A*B) + beta*C on an
//            M x N tile. A*B is built from K outer-product beats, each beat
//            carrying one A column (M elements) and one B row (N elements).
// Ports    : iclk/irst_n      clock, asynchronous active-low reset
//            istart, ik_len   job start request and inner length (clamped
//                             to MATRIX_K), sampled in IDLE only
//            ialpha, ibeta,   scalars and C tile, latched with istart
//            ic_tile
//            ia_col, ib_row,  beat data and valid; oready accepts beats
//            ivalid, oready
//            oresult          R tile (row-major), held until next SCALE
//            obusy, odone     job in progress / one-cycle completion pulse
// Config   : GEMM_SATURATE_EN - when defined the scaled result saturates to
//            the signed DATA_WIDTH range, otherwise it is truncated.
// Revision : 1.0 - initial release
// ============================================================================
module gemm_stream_core #(
    parameter int DATA_WIDTH    = 64,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_WIDTH  = 4,
    parameter int MATRIX_K      = 32,
    parameter int KW            = $clog2(MATRIX_K + 1),
    parameter int ACC_WIDTH     = 2 * DATA_WIDTH + $clog2(MATRIX_K)
) (
    input  logic                                             iclk,
    input  logic                                             irst_n,
    input  logic                                             istart,
    input  logic [KW-1:0]                                    ik_len,
    input  logic [DATA_WIDTH-1:0]                            ialpha,
    input  logic [DATA_WIDTH-1:0]                            ibeta,
    input  logic [MATRIX_HEIGHT*MATRIX_WIDTH*DATA_WIDTH-1:0] ic_tile,
    input  logic [MATRIX_HEIGHT*DATA_WIDTH-1:0]              ia_col,
    input  logic [MATRIX_WIDTH*DATA_WIDTH-1:0]               ib_row,
    input  logic                                             ivalid,
    output logic                                             oready,
    output logic [MATRIX_HEIGHT*MATRIX_WIDTH*DATA_WIDTH-1:0] oresult,
    output logic                                             obusy,
    output logic                                             odone
);

    localparam int M   = MATRIX_HEIGHT;
    localparam int N   = MATRIX_WIDTH;
    localparam int DW  = DATA_WIDTH;
    // Width of alpha*acc + beta*C without any loss.
    localparam int FW  = ACC_WIDTH + DATA_WIDTH + 1;
    localparam logic [KW-1:0] K_MAX = KW'(MATRIX_K);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SCALE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [KW-1:0]         cnt_q, cnt_d;
    logic [KW-1:0]         klen_q, klen_d;
    logic [DW-1:0]         alpha_q, alpha_d;
    logic [DW-1:0]         beta_q, beta_d;
    logic [M*N*DW-1:0]     c_q, c_d;
    logic [M*N*DW-1:0]     result_q, result_d;

    logic [KW-1:0]         w_k_clamped;
    logic                  w_start;
    logic                  w_beat;
    logic [M*N*DW-1:0]     w_res;

    assign w_k_clamped = (ik_len > K_MAX) ? K_MAX : ik_len;
    assign w_start     = (state_q == S_IDLE) && istart;
    // Once count reaches K the engine stays one more cycle in ACCUM with
    // oready low, so a beat presented right after the K-th is never taken.
    assign w_beat      = (state_q == S_ACCUM) && ivalid && (cnt_q != klen_q);

    assign oready  = (state_q == S_ACCUM) && (cnt_q != klen_q);
    assign obusy   = (state_q == S_ACCUM) || (state_q == S_SCALE);
    assign odone   = (state_q == S_DONE);
    assign oresult = result_q;

    // ------------------------------------------------------------------
    // Control: next state and job registers
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        klen_d   = klen_q;
        alpha_d  = alpha_q;
        beta_d   = beta_q;
        c_d      = c_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (istart) begin
                    state_d = (w_k_clamped == '0) ? S_SCALE : S_ACCUM;
                    cnt_d   = '0;
                    klen_d  = w_k_clamped;
                    alpha_d = ialpha;
                    beta_d  = ibeta;
                    c_d     = ic_tile;
                end
            end
            S_ACCUM: begin
                if (w_beat) begin
                    cnt_d = cnt_q + KW'(1);
                end
                if (cnt_q == klen_q) begin
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                state_d  = S_DONE;
                result_d = w_res;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            cnt_q    <= '0;
            klen_q   <= '0;
            alpha_q  <= '0;
            beta_q   <= '0;
            c_q      <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            klen_q   <= klen_d;
            alpha_q  <= alpha_d;
            beta_q   <= beta_d;
            c_q      <= c_d;
            result_q <= result_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-element accumulator and scale stage
    // ------------------------------------------------------------------
    for (genvar gr = 0; gr < M; gr++) begin : g_row
        for (genvar gc = 0; gc < N; gc++) begin : g_col
            logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
            logic signed [ACC_WIDTH-1:0] w_prod;
            logic signed [DW-1:0]        w_a, w_b, w_alpha, w_beta, w_c;
            logic signed [FW-1:0]        w_full;
            logic [DW-1:0]               w_elem;

            always_comb begin
                w_a     = $signed(ia_col[gr*DW +: DW]);
                w_b     = $signed(ib_row[gc*DW +: DW]);
                w_alpha = $signed(alpha_q);
                w_beta  = $signed(beta_q);
                w_c     = $signed(c_q[(gr*N+gc)*DW +: DW]);
                // Operands are sign-extended before multiplying so the
                // product is exact at accumulator width.
                w_prod  = ACC_WIDTH'(w_a) * ACC_WIDTH'(w_b);
                acc_d   = acc_q;
                if (w_start) begin
                    acc_d = '0;
                end else if (w_beat) begin
                    acc_d = acc_q + w_prod;
                end
                w_full  = FW'(w_alpha) * FW'(acc_q) + FW'(w_beta) * FW'(w_c);
            end

`ifdef GEMM_SATURATE_EN
            localparam logic signed [FW-1:0] SAT_MAX =
                {{(FW-DW+1){1'b0}}, {(DW-1){1'b1}}};
            localparam logic signed [FW-1:0] SAT_MIN =
                {{(FW-DW+1){1'b1}}, {(DW-1){1'b0}}};
            always_comb begin
                if (w_full > SAT_MAX) begin
                    w_elem = SAT_MAX[DW-1:0];
                end else if (w_full < SAT_MIN) begin
                    w_elem = SAT_MIN[DW-1:0];
                end else begin
                    w_elem = w_full[DW-1:0];
                end
            end
`else
            logic unused_full_hi;
            assign w_elem         = w_full[DW-1:0];
            assign unused_full_hi = ^w_full[FW-1:DW];
`endif

            assign w_res[(gr*N+gc)*DW +: DW] = w_elem;

            always_ff @(posedge iclk or negedge irst_n) begin
                if (!irst_n) begin
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_d;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gemm_stream_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_gemm_stream_core
// Purpose  : Self-checking bench for gemm_stream_core. A driver issues jobs
//            and beats; expected results come from a plain-arithmetic GEMM
//            model and are queued; a monitor checks them on every odone.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gemm_stream_core;

    localparam int DW = 16;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int MK = 32;
    localparam int KW = $clog2(MK + 1);

    logic               iclk    = 1'b0;
    logic               irst_n  = 1'b0;
    logic               istart  = 1'b0;
    logic [KW-1:0]      ik_len  = '0;
    logic [DW-1:0]      ialpha  = '0;
    logic [DW-1:0]      ibeta   = '0;
    logic [M*N*DW-1:0]  ic_tile = '0;
    logic [M*DW-1:0]    ia_col  = '0;
    logic [N*DW-1:0]    ib_row  = '0;
    logic               ivalid  = 1'b0;
    logic               oready;
    logic [M*N*DW-1:0]  oresult;
    logic               obusy;
    logic               odone;

    gemm_stream_core #(
        .DATA_WIDTH   (DW),
        .MATRIX_HEIGHT(M),
        .MATRIX_WIDTH (N),
        .MATRIX_K     (MK)
    ) dut (
        .iclk   (iclk),
        .irst_n (irst_n),
        .istart (istart),
        .ik_len (ik_len),
        .ialpha (ialpha),
        .ibeta  (ibeta),
        .ic_tile(ic_tile),
        .ia_col (ia_col),
        .ib_row (ib_row),
        .ivalid (ivalid),
        .oready (oready),
        .oresult(oresult),
        .obusy  (obusy),
        .odone  (odone)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    typedef struct {
        logic [M*N*DW-1:0] res;
        int                done_cyc;
        int                beats;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int beat_cnt    = 0;
    int bad_ready   = 0;

    longint A_m [M][MK];
    longint B_m [MK][N];
    longint C_m [M][N];
    logic [M*N*DW-1:0] last_res = '0;

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] reduce(input longint v);
        longint x;
        x = v;
`ifdef GEMM_SATURATE_EN
        begin
            longint hi;
            longint lo;
            hi = (longint'(1) <<< (DW - 1)) - 1;
            lo = -(longint'(1) <<< (DW - 1));
            if (x > hi) x = hi;
            if (x < lo) x = lo;
        end
`endif
        return x[DW-1:0];
    endfunction

    function automatic logic [M*N*DW-1:0] model(input int keff, input longint alpha,
                                                input longint beta);
        logic [M*N*DW-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                longint s;
                s = 0;
                for (int k = 0; k < keff; k++) s += A_m[i][k] * B_m[k][j];
                r[(i*N+j)*DW +: DW] = reduce(alpha * s + beta * C_m[i][j]);
            end
        end
        return r;
    endfunction

    function automatic longint rnd();
        logic [31:0]          u;
        logic signed [DW-1:0] t;
        u = $urandom;
        t = u[DW-1:0];
        return longint'(t);
    endfunction

    task automatic chk(input string name, input logic [M*N*DW-1:0] got,
                       input logic [M*N*DW-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // ---------------- driver ----------------
    task automatic start_job(input int klen, input longint alpha, input longint beta,
                             input bit chk_lat);
        exp_t   e;
        int     keff;
        longint v;
        keff   = (klen > MK) ? MK : klen;
        ik_len = klen[KW-1:0];
        ialpha = alpha[DW-1:0];
        ibeta  = beta[DW-1:0];
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                v = C_m[i][j];
                ic_tile[(i*N+j)*DW +: DW] = v[DW-1:0];
            end
        end
        e.res      = model(keff, alpha, beta);
        e.beats    = keff;
        e.done_cyc = chk_lat ? cyc + ((keff == 0) ? 2 : keff + 3) : -1;
        sb.push_back(e);
        istart = 1'b1;
        @(posedge iclk);
        #1;
        istart = 1'b0;
        chk("hold_result", oresult, last_res);
        last_res = e.res;
    endtask

    task automatic feed_beats(input int n, input bit stall, input bit noise);
        int     i;
        int     guard;
        bit     tog;
        bit     acc;
        longint v;
        i     = 0;
        guard = 0;
        tog   = 1'b1;
        while (i < n && guard < 400) begin
            ivalid = stall ? tog : 1'b1;
            tog    = ~tog;
            for (int r = 0; r < M; r++) begin
                v = A_m[r][i];
                ia_col[r*DW +: DW] = v[DW-1:0];
            end
            for (int c = 0; c < N; c++) begin
                v = B_m[i][c];
                ib_row[c*DW +: DW] = v[DW-1:0];
            end
            if (noise) begin
                istart  = 1'($urandom_range(1, 0));
                ik_len  = KW'($urandom_range(MK, 0));
                ialpha  = DW'($urandom_range(65535, 0));
                ibeta   = DW'($urandom_range(65535, 0));
                ic_tile = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, $urandom};
            end
            @(negedge iclk);
            acc = ivalid && oready;
            @(posedge iclk);
            #1;
            if (acc) i++;
            guard++;
        end
        istart = 1'b0;
        if (i < n) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_timeout: got %0d beats accepted, expected %0d", i, n);
        end
        // Keep offering junk beats; none may be taken after the K-th.
        ivalid = 1'b1;
        ia_col = {$urandom, $urandom};
        ib_row = {$urandom, $urandom};
    endtask

    task automatic wait_done();
        int start;
        int g;
        start = done_cnt;
        g     = 0;
        while (done_cnt == start && g < 200) begin
            @(posedge iclk);
            g++;
        end
        if (done_cnt == start) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no odone, expected one within 200 cycles");
            if (sb.size() > 0) void'(sb.pop_back());
        end
        ivalid = 1'b0;
        @(posedge iclk);
        #1;
    endtask

    task automatic fill_identity();
        for (int i = 0; i < M; i++)
            for (int k = 0; k < MK; k++) A_m[i][k] = (i == k) ? 1 : 0;
        for (int k = 0; k < MK; k++)
            for (int j = 0; j < N; j++) B_m[k][j] = (k < 4) ? k * N + j + 1 : 0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) C_m[i][j] = rnd();
    endtask

    task automatic fill_random();
        for (int i = 0; i < M; i++)
            for (int k = 0; k < MK; k++) A_m[i][k] = rnd();
        for (int k = 0; k < MK; k++)
            for (int j = 0; j < N; j++) B_m[k][j] = rnd();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) C_m[i][j] = rnd();
    endtask

    task automatic fill_const(input longint a, input longint b, input longint c);
        for (int i = 0; i < M; i++)
            for (int k = 0; k < MK; k++) A_m[i][k] = a;
        for (int k = 0; k < MK; k++)
            for (int j = 0; j < N; j++) B_m[k][j] = b;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) C_m[i][j] = c;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge iclk) begin
        if (!irst_n) begin
            beat_cnt  = 0;
            bad_ready = 0;
        end else begin
            if (oready && !obusy) bad_ready++;
            if (ivalid && oready) beat_cnt++;
            if (odone) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got odone at cycle %0d, expected none", cyc);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", oresult, mon_e.res);
                    vectors++;
                    if (beat_cnt != mon_e.beats) begin
                        miscompares++;
                        $display("FAIL beats: got %0d, expected %0d", beat_cnt, mon_e.beats);
                    end
                    vectors++;
                    if (bad_ready != 0) begin
                        miscompares++;
                        $display("FAIL ready_outside_busy: got %0d cycles, expected 0", bad_ready);
                    end
                    if (mon_e.done_cyc >= 0) begin
                        vectors++;
                        if (cyc != mon_e.done_cyc) begin
                            miscompares++;
                            $display("FAIL latency: got odone at cycle %0d, expected %0d",
                                     cyc, mon_e.done_cyc);
                        end
                    end
                end
                beat_cnt  = 0;
                bad_ready = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge iclk);
        #1;
        chk("reset_result", oresult, '0);
        chk("reset_flags", {{(M*N*DW-3){1'b0}}, oready, obusy, odone}, '0);
        @(negedge iclk);
        irst_n = 1'b1;
        @(posedge iclk);
        #1;

        // Identity: R = B
        fill_identity();
        start_job(4, 1, 0, 1'b1);
        feed_beats(4, 1'b0, 1'b0);
        wait_done();

        // Scale and bias with noise on start-side inputs while busy
        fill_const(2, 3, 5);
        start_job(32, 2, -1, 1'b1);
        feed_beats(32, 1'b0, 1'b1);
        wait_done();

        // Identity with alternating stalls
        fill_identity();
        start_job(4, 1, 0, 1'b0);
        feed_beats(4, 1'b1, 1'b0);
        wait_done();

        // K = 0: R = 3*C
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) C_m[i][j] = i * 4 + j;
        start_job(0, rnd(), 3, 1'b1);
        feed_beats(0, 1'b0, 1'b0);
        wait_done();

        // Positive and negative overflow of the output width
        fill_const(32767, 32767, 0);
        start_job(4, 1, 0, 1'b1);
        feed_beats(4, 1'b0, 1'b0);
        wait_done();
        fill_const(-32768, 32767, 7);
        start_job(4, 1, 1, 1'b1);
        feed_beats(4, 1'b0, 1'b0);
        wait_done();

        // Abort mid-ACCUM with reset, then a fresh job
        fill_identity();
        start_job(4, 1, 0, 1'b0);
        feed_beats(2, 1'b0, 1'b0);
        irst_n = 1'b0;
        #1;
        chk("abort_result", oresult, '0);
        chk("abort_flags", {{(M*N*DW-3){1'b0}}, oready, obusy, odone}, '0);
        void'(sb.pop_back());
        last_res = '0;
        ivalid   = 1'b0;
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        irst_n = 1'b1;
        @(posedge iclk);
        #1;
        fill_identity();
        start_job(4, 1, 0, 1'b1);
        feed_beats(4, 1'b0, 1'b0);
        wait_done();

        // ik_len above MATRIX_K clamps to MATRIX_K
        fill_random();
        start_job(40, rnd(), rnd(), 1'b1);
        feed_beats(MK, 1'b0, 1'b0);
        wait_done();

        // Randomised jobs
        for (int t = 0; t < 8; t++) begin
            int  kl;
            bit  st;
            int  ke;
            kl = $urandom_range(MK + 2, 0);
            st = 1'($urandom_range(1, 0));
            ke = (kl > MK) ? MK : kl;
            fill_random();
            start_job(kl, rnd(), rnd(), !st);
            feed_beats(ke, st, 1'($urandom_range(1, 0)));
            wait_done();
        end

        repeat (4) @(posedge iclk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover: got %0d pending results, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
